pcm_interp: RTL

Upstream feeder for the PDM DAC stage. Accepts offset-binary PCM samples over a valid/ready handshake into a small FIFO. Dequeues one sample per 48 kHz `sample_tick` and linearly interpolates between consecutive samples on each `step_tick`. Drives the PDM modulator's `sample` input with a smoothly stepped value instead of a 48 kHz staircase.

---
 rtl/pcm_interp.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pcm_interp.sv
// PCM sample FIFO feeding a linear interpolator: one sample is dequeued per
// sample_tick and the output ramps toward it in 2^INTERP_LOG2 step_tick steps.
module pcm_interp #(
    parameter int INPUT_WIDTH = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int INTERP_LOG2 = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [INPUT_WIDTH-1:0]        in_sample,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          sample_tick,
    input  logic                          step_tick,
    input  logic                          underrun_clr,
    output logic [INPUT_WIDTH-1:0]        out_sample,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun
);
    localparam int W  = INPUT_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int KW = INTERP_LOG2 + 1;
    localparam int PW = INPUT_WIDTH + INTERP_LOG2 + 2;

    localparam logic [W-1:0]  MIDSCALE   = W'(1) << (W - 1);
    localparam logic [KW-1:0] K_MAX      = KW'(1) << INTERP_LOG2;
    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

    logic [W-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [W-1:0]  prev_q, prev_d;
    logic [W-1:0]  target_q, target_d;
    logic [KW-1:0] k_q, k_d;
    logic          underrun_q, underrun_d;
    logic [W-1:0]  out_q, out_d;

    logic fifo_empty, fifo_full, push, pop;

    logic signed [W:0]    diff;
    logic signed [PW-1:0] diff_ext, k_ext, prod, step_off, sum;
    logic                 sum_unused;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LEVEL_FULL);
    // Ready is held low during reset so nothing is offered into a FIFO being cleared.
    assign in_ready   = !reset && !fifo_full;
    assign push       = in_valid && in_ready;
    assign pop        = sample_tick && !fifo_empty;

    // Interpolation: prev + floor((target - prev) * k / N), truncated to W bits.
    assign diff       = $signed({1'b0, target_q}) - $signed({1'b0, prev_q});
    assign diff_ext   = {{(PW - W - 1){diff[W]}}, diff};
    assign k_ext      = {{(PW - KW){1'b0}}, k_q};
    assign prod       = diff_ext * k_ext;
    assign step_off   = prod >>> INTERP_LOG2;
    assign sum        = $signed({{(PW - W){1'b0}}, prev_q}) + step_off;
    assign sum_unused = ^sum[PW-1:W];
    assign out_d      = sum[W-1:0];

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        prev_d     = prev_q;
        target_d   = target_q;
        k_d        = k_q;
        underrun_d = underrun_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // A sample tick always restarts the ramp; a coincident step is dropped.
        if (sample_tick) begin
            prev_d = target_q;
            k_d    = '0;
            if (!fifo_empty) target_d = mem_q[rd_ptr_q];
        end else if (step_tick && (k_q != K_MAX)) begin
            k_d = k_q + KW'(1);
        end

        if (underrun_clr)               underrun_d = 1'b0;
        if (sample_tick && fifo_empty)  underrun_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_sample;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            prev_q     <= MIDSCALE;
            target_q   <= MIDSCALE;
            k_q        <= K_MAX;
            underrun_q <= 1'b0;
            out_q      <= MIDSCALE;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            prev_q     <= prev_d;
            target_q   <= target_d;
            k_q        <= k_d;
            underrun_q <= underrun_d;
            out_q      <= out_d;
        end
    end

    assign out_sample = out_q;
    assign fifo_level = level_q;
    assign underrun   = underrun_q;

endmodule
